leaves_mem_loader: RTL and testbench

Write-side producer for the leaf memory: accepts a serial stream of patches over a valid/ready handshake, packs every LEAF_SIZE consecutive patches into one leaf-wide word, and issues one full-leaf write per leaf with a sequential leaf address. It sits between the tree-build/leaf-sorting datapath and the leaf memory write port. It owns leaf numbering from 0 to NUM_LEAVES-1 for one load pass.

---
 rtl/leaves_mem_loader_pkg.sv | 21 ++
 rtl/leaves_mem_loader_buf.sv | 41 ++++
 rtl/leaves_mem_loader.sv | 126 ++++++++++++
 tb/tb_leaves_mem_loader.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/leaves_mem_loader_pkg.sv
// Shared types and default sizes for the leaf memory write path.
// The leaf memory uses the same defaults, so both sides agree on the word layout.
package leaves_mem_loader_pkg;

  localparam int DEF_DATA_WIDTH = 11;
  localparam int DEF_LEAF_SIZE  = 8;
  localparam int DEF_PATCH_SIZE = 5;
  localparam int DEF_NUM_LEAVES = 64;
  localparam int DEF_ADDR_WIDTH = $clog2(DEF_NUM_LEAVES);

  typedef logic [DEF_PATCH_SIZE-1:0][DEF_DATA_WIDTH-1:0] patch_t;
  typedef patch_t [DEF_LEAF_SIZE-1:0] leaf_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/leaves_mem_loader_buf.sv
// leaf_pack_buf: LEAF_SIZE-slot patch register file. One indexed patch write
// per cycle, plus an optional zero-fill of every slot at or above zfrom.
// An indexed write takes priority over the zero-fill for the same slot.
module leaf_pack_buf
  import leaves_mem_loader_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int PATCH_SIZE = DEF_PATCH_SIZE,
  parameter int LEAF_SIZE  = DEF_LEAF_SIZE,
  parameter int IDX_W      = $clog2(DEF_LEAF_SIZE)
)(
  input  logic                                           clk,
  input  logic                                           rst_n,
  input  logic                                           we,
  input  logic [IDX_W-1:0]                               widx,
  input  logic [PATCH_SIZE-1:0][DATA_WIDTH-1:0]          wpatch,
  input  logic                                           zf,
  input  logic [IDX_W:0]                                 zfrom,
  output logic [LEAF_SIZE-1:0][PATCH_SIZE-1:0][DATA_WIDTH-1:0] leaf
);

  logic [LEAF_SIZE-1:0][PATCH_SIZE-1:0][DATA_WIDTH-1:0] slots;

  // Slot storage: indexed write, else zero-fill of the unused tail of a leaf.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slots <= '0;
    end else begin
      for (int i = 0; i < LEAF_SIZE; i++) begin
        if (we && (widx == IDX_W'(i))) begin
          slots[i] <= wpatch;
        end else if (zf && ((IDX_W+1)'(i) >= zfrom)) begin
          slots[i] <= '0;
        end
      end
    end
  end

  assign leaf = slots;

endmodule

// File: rtl/leaves_mem_loader.sv
// leaves_mem_loader: packs LEAF_SIZE serially received patches into one
// leaf-wide word and writes it to the leaf memory at a sequential address.
// Optional feature macro: LEAVES_LOADER_FLUSH_EN adds the flush port, which
// closes a partial leaf (zero-padded) and ends the pass early.
module leaves_mem_loader
  import leaves_mem_loader_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LEAF_SIZE  = DEF_LEAF_SIZE,
  parameter int PATCH_SIZE = DEF_PATCH_SIZE,
  parameter int NUM_LEAVES = DEF_NUM_LEAVES,
  parameter int ADDR_WIDTH = $clog2(NUM_LEAVES)
)(
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  start,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [PATCH_SIZE-1:0][DATA_WIDTH-1:0] in_patch,
`ifdef LEAVES_LOADER_FLUSH_EN
  input  logic                                  flush,
`endif
  output logic                                  wen,
  output logic [ADDR_WIDTH-1:0]                 wadr,
  output logic [LEAF_SIZE-1:0][PATCH_SIZE-1:0][DATA_WIDTH-1:0] wdata,
  output logic                                  busy,
  output logic                                  done,
  output logic [ADDR_WIDTH:0]                   leaf_count
);

  localparam int PW = $clog2(LEAF_SIZE);

  state_t          state;
  logic [PW-1:0]   pidx;
  logic [ADDR_WIDTH-1:0] lidx;
  logic            end_pass;   // write in progress is the last one of the pass
  logic            hs;
  logic            last_slot;
  logic            flush_eff;
  logic [PW:0]     fill_cnt;   // slots occupied once this cycle's handshake lands

`ifdef LEAVES_LOADER_FLUSH_EN
  assign flush_eff = flush;
`else
  assign flush_eff = 1'b0;
`endif

  assign hs        = in_valid && in_ready;
  assign last_slot = (pidx == PW'(LEAF_SIZE-1));
  assign fill_cnt  = {1'b0, pidx} + {{PW{1'b0}}, hs};

  // Outputs decode directly from the state and index flops.
  assign in_ready = (state == FILL);
  assign wen      = (state == WRITE);
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);
  assign wadr     = lidx;

  leaf_pack_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .PATCH_SIZE (PATCH_SIZE),
    .LEAF_SIZE  (LEAF_SIZE),
    .IDX_W      (PW)
  ) u_buf (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (hs),
    .widx   (pidx),
    .wpatch (in_patch),
    .zf     ((state == FILL) && flush_eff),
    .zfrom  (fill_cnt),
    .leaf   (wdata)
  );

  // Pass sequencing: fill a leaf, spend one cycle writing it, repeat, then pulse done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pidx       <= '0;
      lidx       <= '0;
      leaf_count <= '0;
      end_pass   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state      <= FILL;
            pidx       <= '0;
            lidx       <= '0;
            leaf_count <= '0;
            end_pass   <= 1'b0;
          end
        end
        FILL: begin
          if (hs) begin
            pidx <= last_slot ? '0 : pidx + 1'b1;
          end
          if (hs && last_slot) begin
            state    <= WRITE;
            end_pass <= flush_eff;
          end else if (flush_eff && (fill_cnt != '0)) begin
            state    <= WRITE;
            end_pass <= 1'b1;
            pidx     <= '0;
          end else if (flush_eff) begin
            state <= DONE;
          end
        end
        WRITE: begin
          leaf_count <= leaf_count + 1'b1;
          if (end_pass || (lidx == ADDR_WIDTH'(NUM_LEAVES-1))) begin
            state <= DONE;
          end else begin
            lidx  <= lidx + 1'b1;
            state <= FILL;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_leaves_mem_loader.sv
// Bench for leaves_mem_loader: a directed vector table for the first leaf,
// then randomized passes scored against a transaction-level model
// (accepted-patch queue, leaf and write counters).
module tb_leaves_mem_loader;
  import leaves_mem_loader_pkg::*;

  localparam int DW = DEF_DATA_WIDTH;
  localparam int LS = DEF_LEAF_SIZE;
  localparam int PS = DEF_PATCH_SIZE;
  localparam int NL = DEF_NUM_LEAVES;
  localparam int AW = DEF_ADDR_WIDTH;
`ifdef LEAVES_LOADER_FLUSH_EN
  localparam bit FLUSH_ON = 1'b1;
`else
  localparam bit FLUSH_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          in_valid;
  logic          in_ready;
  patch_t        in_patch;
  logic          flush;
  logic          wen;
  logic [AW-1:0] wadr;
  leaf_t         wdata;
  logic          busy;
  logic          done;
  logic [AW:0]   leaf_count;

  int total = 0;
  int bad   = 0;
  int n_done;

  leaves_mem_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_patch   (in_patch),
`ifdef LEAVES_LOADER_FLUSH_EN
    .flush      (flush),
`endif
    .wen        (wen),
    .wadr       (wadr),
    .wdata      (wdata),
    .busy       (busy),
    .done       (done),
    .leaf_count (leaf_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- transaction-level reference model ----------------
  bit     m_on, m_wr, m_done, m_end;
  int     m_acc, m_writes;
  patch_t q[$];

  task automatic model_reset();
    m_on = 0; m_wr = 0; m_done = 0; m_end = 0;
    m_acc = 0; m_writes = 0;
    q.delete();
  endtask

  task automatic model_step(input bit st, input bit v, input bit fl, input patch_t p);
    bit fle;
    fle = fl && FLUSH_ON;
    if (!m_on) begin
      if (st) begin
        model_reset();
        m_on = 1;
      end
    end else if (m_done) begin
      m_done = 0;
      m_on   = 0;
    end else if (m_wr) begin
      m_wr = 0;
      m_writes++;
      if (m_end || m_writes == NL) m_done = 1;
    end else begin
      if (v) begin
        q.push_back(p);
        m_acc++;
        if (m_acc % LS == 0) m_wr = 1;
      end
      if (fle) begin
        if (m_acc % LS != 0) begin
          while (m_acc % LS != 0) begin
            q.push_back('0);
            m_acc++;
          end
          m_wr  = 1;
          m_end = 1;
        end else if (v) begin
          m_end = 1;
        end else begin
          m_done = 1;
        end
      end
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_leaf(input string nm, input leaf_t act, input leaf_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic check_all();
    leaf_t exp;
    chk("in_ready", in_ready, m_on && !m_wr && !m_done);
    chk("wen", wen, m_wr);
    chk("busy", busy, m_on);
    chk("done", done, m_done);
    chk("leaf_count", leaf_count, m_writes);
    if (m_wr) begin
      chk("wadr", wadr, m_writes);
      for (int s = 0; s < LS; s++) exp[s] = q[m_writes * LS + s];
      chk_leaf("wdata", wdata, exp);
    end
    if (done) n_done++;
  endtask

  task automatic chk_reset_vals();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_wen", wen, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_leaf_count", leaf_count, 0);
    chk("rst_wadr", wadr, 0);
    chk_leaf("rst_wdata", wdata, '0);
  endtask

  function automatic patch_t rp();
    patch_t p;
    for (int e = 0; e < PS; e++) p[e] = DW'($urandom);
    return p;
  endfunction

  function automatic patch_t cp(input int val);
    patch_t p;
    for (int e = 0; e < PS; e++) p[e] = DW'(val);
    return p;
  endfunction

  task automatic cyc(input bit st, input bit v, input bit fl, input patch_t p);
    start = st; in_valid = v; flush = fl; in_patch = p;
    @(posedge clk);
    model_step(st, v, fl, p);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 0; in_valid = 0; flush = 0;
    #1;
    chk_reset_vals();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit st;
    bit v;
    int val;
    bit rdy;
    bit wen;
    bit busy;
    int cnt;
    bit chkdat;
  } vec_t;

  vec_t  tbl[10];
  leaf_t exp18;

  initial begin
    rst_n = 1'b0; start = 0; in_valid = 0; flush = 0; in_patch = '0;
    n_done = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals();
    rst_n = 1'b1;

    // First leaf, patches 1..8 back-to-back, then a patch offered during WRITE.
    tbl[0] = '{st:1, v:0, val:0, rdy:1, wen:0, busy:1, cnt:0, chkdat:0};
    for (int i = 1; i <= 8; i++)
      tbl[i] = '{st:0, v:1, val:i, rdy:(i < 8), wen:(i == 8), busy:1, cnt:0, chkdat:(i == 8)};
    tbl[9] = '{st:0, v:1, val:99, rdy:1, wen:0, busy:1, cnt:1, chkdat:0};
    for (int s = 0; s < LS; s++) exp18[s] = cp(s + 1);

    for (int i = 0; i < 10; i++) begin
      start = tbl[i].st; in_valid = tbl[i].v; flush = 0; in_patch = cp(tbl[i].val);
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_in_ready", i), in_ready, tbl[i].rdy);
      chk($sformatf("tbl%0d_wen", i), wen, tbl[i].wen);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].busy);
      chk($sformatf("tbl%0d_leaf_count", i), leaf_count, tbl[i].cnt);
      if (tbl[i].chkdat) begin
        chk("tbl_wadr", wadr, 0);
        chk_leaf("tbl_wdata", wdata, exp18);
      end
    end

    do_reset();

    // Full pass with random gaps, random start pulses while busy.
    n_done = 0;
    cyc(1, 0, 0, rp());
    for (int n = 0; n < 3000 && m_on; n++)
      cyc(($urandom % 16) == 0, ($urandom % 10) < 7, 0, rp());
    if (m_on) begin
      total++; bad++;
      $display("FAIL full_pass_timeout: got=busy want=idle");
    end
    chk("done_pulses", n_done, 1);
    chk("final_leaf_count", leaf_count, NL);

    // Idle: in_valid offered, nothing accepted, count held.
    for (int n = 0; n < 4; n++) cyc(0, 1, 0, rp());

    // Reset after 3 patches of leaf 5.
    cyc(1, 0, 0, rp());
    for (int n = 0; n < 400 && m_acc < 5 * LS + 3; n++)
      cyc(0, ($urandom % 4) != 0, 0, rp());
    if (m_acc != 5 * LS + 3) begin
      total++; bad++;
      $display("FAIL reach_leaf5: got=%0d want=%0d", m_acc, 5 * LS + 3);
    end
    do_reset();
    cyc(1, 0, 0, rp());
    for (int n = 0; n < LS; n++) cyc(0, 1, 0, rp());
    for (int n = 0; n < 3; n++) cyc(0, ($urandom % 2) == 1, 0, rp());

`ifdef LEAVES_LOADER_FLUSH_EN
    do_reset();
    // 3 patches then flush: zero-padded write then done.
    cyc(1, 0, 0, rp());
    for (int n = 0; n < 3; n++) cyc(0, 1, 0, rp());
    cyc(0, 0, 1, rp());
    for (int n = 0; n < 4; n++) cyc(0, 0, 0, rp());
    // Flush at an empty leaf: done, no write.
    cyc(1, 0, 0, rp());
    cyc(0, 0, 1, rp());
    for (int n = 0; n < 3; n++) cyc(0, 0, 0, rp());
    // Flush coincident with the 8th handshake of leaf 1.
    cyc(1, 0, 0, rp());
    for (int n = 0; n < LS + 1 + LS - 1; n++) cyc(0, 1, 0, rp());
    cyc(0, 1, 1, rp());
    for (int n = 0; n < 4; n++) cyc(0, 0, 0, rp());
    // Flush coincident with a mid-leaf handshake.
    cyc(1, 0, 0, rp());
    for (int n = 0; n < 4; n++) cyc(0, 1, 0, rp());
    cyc(0, 1, 1, rp());
    for (int n = 0; n < 4; n++) cyc(0, 0, 0, rp());
    // Flush outside FILL is ignored.
    cyc(0, 0, 1, rp());
    cyc(0, 0, 1, rp());
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
